serial_seq_detector: RTL and testbench

Upstream stage of the serial receive path. Watches the 1-bit serial stream for a parameterised start pattern and drives a registered one-cycle seqValid pulse into the receive controller. That controller then reads the payload bits and transmits the result. The detector re-arms only after the controller reports it is idle again.

---
 rtl/serial_seq_detector.sv | 92 +++++++++
 tb/tb_serial_seq_detector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_seq_detector.sv
// serial_seq_detector: finds a start pattern in a 1-bit serial stream and
// pulses seqValid for one cycle, then waits for the receive controller.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bitIn      serial data bit
//   bitValid   qualifies bitIn
//   busy       downstream controller is reading payload / transmitting
//   clrCount   synchronous clear of matchCount
//   seqValid   registered one-cycle pulse: pattern just completed
//   armed      next valid bit can complete a match
//   matchCount saturating count of seqValid pulses
module serial_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
    parameter int                     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bitIn,
    input  logic             bitValid,
    input  logic             busy,
    input  logic             clrCount,
    output logic             seqValid,
    output logic             armed,
    output logic [CNT_W-1:0] matchCount
);

    localparam int FW = $clog2(PATTERN_LEN);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]             state;
    logic [PATTERN_LEN-2:0] win;
    logic [FW-1:0]          fill;
    logic [PATTERN_LEN-1:0] cand;
    logic                   hit;

    assign cand = {win, bitIn};

    // fill gating keeps a reset-zero window from matching a pattern
    // with leading zeros before enough real bits have arrived.
    assign hit = (state == S_FILL) && !busy && bitValid &&
                 (fill == FULL) && (cand == PATTERN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FILL;
            win      <= '0;
            fill     <= '0;
            seqValid <= 1'b0;
        end else begin
            seqValid <= hit;
            if (state == S_HOLD) begin
                // bit in this cycle belongs to the payload; not sampled
                state <= S_FILL;
            end else if (busy) begin
                win  <= '0;
                fill <= '0;
            end else if (bitValid) begin
                if (hit) begin
                    // matched bits are never reused for the next match
                    win   <= '0;
                    fill  <= '0;
                    state <= S_HOLD;
                end else begin
                    win <= cand[PATTERN_LEN-2:0];
                    if (fill != FULL) begin
                        fill <= fill + 1'b1;
                    end
                end
            end
        end
    end

    // Counts at the same edge that raises seqValid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matchCount <= '0;
        end else if (clrCount) begin
            matchCount <= '0;
        end else if (hit && (matchCount != {CNT_W{1'b1}})) begin
            matchCount <= matchCount + 1'b1;
        end
    end

    assign armed = (state == S_FILL) && (fill == FULL) && !busy;

endmodule

// File: tb/tb_serial_seq_detector.sv
// tb_serial_seq_detector: three detector configurations driven by one
// shared stream, checked against directed expectations and a queue model.
module tb_serial_seq_detector;

    logic clk;
    logic rst;
    logic bitIn;
    logic bitValid;
    logic busy;
    logic clrCount;

    logic [2:0] sv_w;
    logic [2:0] arm_w;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    serial_seq_detector u_d0 (
        .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid),
        .busy(busy), .clrCount(clrCount), .seqValid(sv_w[0]),
        .armed(arm_w[0]), .matchCount(cnt0)
    );

    serial_seq_detector #(.PATTERN(4'b0001)) u_d1 (
        .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid),
        .busy(busy), .clrCount(clrCount), .seqValid(sv_w[1]),
        .armed(arm_w[1]), .matchCount(cnt1)
    );

    serial_seq_detector #(.CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid),
        .busy(busy), .clrCount(clrCount), .seqValid(sv_w[2]),
        .armed(arm_w[2]), .matchCount(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: a queue of the most recent valid bits since the
    // last clear; a match is the last PATTERN_LEN bits equal to pattern.
    localparam int L = 4;
    int mq[3][$];
    bit mhold[3];
    bit msv[3];
    int mcnt[3];
    int mpat[3] = '{13, 1, 13};
    int mmax[3] = '{255, 255, 3};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mhold[i] = 1'b0;
            msv[i] = 1'b0;
            mcnt[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit hit;
            int val;
            hit = 1'b0;
            val = 0;
            if (mhold[i]) begin
                mhold[i] = 1'b0;
            end else if (busy) begin
                mq[i].delete();
            end else if (bitValid) begin
                mq[i].push_back(int'(bitIn));
                if (mq[i].size() == L) begin
                    for (int k = 0; k < L; k++) val = val * 2 + mq[i][k];
                    if (val == mpat[i]) begin
                        hit = 1'b1;
                        mq[i].delete();
                        mhold[i] = 1'b1;
                    end else begin
                        void'(mq[i].pop_front());
                    end
                end
            end
            msv[i] = hit;
            if (clrCount) mcnt[i] = 0;
            else if (hit && mcnt[i] < mmax[i]) mcnt[i]++;
        end
    endtask

    task automatic compare_all();
        logic [7:0] c[3];
        c[0] = cnt0;
        c[1] = cnt1;
        c[2] = {6'b0, cnt2};
        for (int i = 0; i < 3; i++) begin
            bit marm;
            marm = !mhold[i] && (mq[i].size() == L - 1) && !busy;
            chk($sformatf("model_sv%0d", i), 32'(sv_w[i]), 32'(msv[i]));
            chk($sformatf("model_arm%0d", i), 32'(arm_w[i]), 32'(marm));
            chk($sformatf("model_cnt%0d", i), 32'(c[i]), mcnt[i]);
        end
    endtask

    task automatic cycle(input logic b, input logic v,
                         input logic bz, input logic c);
        bitIn = b;
        bitValid = v;
        busy = bz;
        clrCount = c;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_sv"}, 32'(sv_w), 0);
        chk({nm, "_arm"}, 32'(arm_w), 0);
        chk({nm, "_cnt0"}, 32'(cnt0), 0);
        chk({nm, "_cnt1"}, 32'(cnt1), 0);
        chk({nm, "_cnt2"}, 32'(cnt2), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic b;
        logic v;
        logic bz;
        logic c;
        logic sv;
        logic arm;
        int   cnt;
    } vec_t;

    vec_t tbl[$];
    int   exp6[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        rst = 1'b1;
        bitIn = 1'b0;
        bitValid = 1'b0;
        busy = 1'b0;
        clrCount = 1'b0;
        model_reset();

        // single match, HOLD filler, overlapping prefix, ignored bit,
        // then gapped bitValid
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 2});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 1, 2});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 3});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 3});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 4});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4});

        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].b, tbl[i].v, tbl[i].bz, tbl[i].c);
            chk($sformatf("tbl%0d_sv", i), 32'(sv_w[0]), 32'(tbl[i].sv));
            chk($sformatf("tbl%0d_arm", i), 32'(arm_w[0]), 32'(tbl[i].arm));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt0), tbl[i].cnt);
        end

        // leading-zero pattern must not match on a reset-zero window
        do_reset();
        cycle(1, 1, 0, 0);
        chk("lz_first", 32'(sv_w[1]), 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("lz_pre", 32'(sv_w[1]), 0);
        cycle(1, 1, 0, 0);
        chk("lz_hit", 32'(sv_w[1]), 1);
        cycle(0, 1, 0, 0);
        chk("lz_once", 32'(sv_w[1]), 0);

        // busy blocks matching and clears a partial window
        do_reset();
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        chk("busy_nohit", 32'(sv_w[0]), 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("busy_armed", 32'(arm_w[0]), 1);
        cycle(0, 0, 1, 0);
        chk("busy_disarm", 32'(arm_w[0]), 0);
        cycle(1, 1, 0, 0);
        chk("busy_restart_sv", 32'(sv_w[0]), 0);
        chk("busy_restart_arm", 32'(arm_w[0]), 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("busy_after_hit", 32'(sv_w[0]), 1);

        // saturating 2-bit counter
        do_reset();
        for (int p = 0; p < 6; p++) begin
            cycle(1, 1, 0, 0);
            cycle(1, 1, 0, 0);
            cycle(0, 1, 0, 0);
            cycle(1, 1, 0, 0);
            chk($sformatf("sat%0d_sv", p), 32'(sv_w[2]), 1);
            chk($sformatf("sat%0d_cnt", p), 32'(cnt2), exp6[p]);
            cycle(0, 1, 0, 0);
        end
        chk("sat_wide_cnt", 32'(cnt0), 6);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 1);
        chk("clr_hit_sv", 32'(sv_w[2]), 1);
        chk("clr_hit_cnt", 32'(cnt2), 0);
        cycle(0, 1, 0, 0);

        // reset in the middle of a pattern
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        do_reset();
        cycle(1, 1, 0, 0);
        check_zero("mid_rst");

        // random stream against the model
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) do_reset();
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
